lzy_gate_pipe: RTL and testbench



---
 rtl/lzy_gate_pkg.sv | 18 +
 rtl/lzy_gate_logic.sv | 28 ++
 rtl/lzy_gate_pipe.sv | 116 +++++++++++
 tb/tb_lzy_gate_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzy_gate_pkg.sv
// Shared types and default sizes for the pipelined basic-gate block.
package lzy_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_NAND  = 3'd1,
    OP_OR    = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSB = 3'd7
  } gate_op_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/lzy_gate_logic.sv
// Combinational bitwise gate: applies one of eight operations to a and b.
module lzy_gate_logic
  import lzy_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_NAND:  y = ~(a & b);
      OP_OR:    y = a | b;
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/lzy_gate_pipe.sv
// Two-stage valid/ready gate pipeline with a wrapping completed-transfer counter.
// Optional out_par output is present only when LZY_GATE_PARITY_EN is defined.
module lzy_gate_pipe
  import lzy_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
  output logic             out_zero,
`ifdef LZY_GATE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] done_cnt
);

  logic             s1_valid_reg;
  logic [2:0]       s1_op_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;

  logic             s2_valid_reg;
  logic [2:0]       s2_op_reg;
  logic [WIDTH-1:0] s2_y_reg;
  logic             s2_zero_reg;
  logic [CNT_W-1:0] done_cnt_reg;

  logic [WIDTH-1:0] y_next;
  logic             in_xfer;
  logic             out_xfer;
  logic             s2_load;

  lzy_gate_logic #(.WIDTH(WIDTH)) u_logic (
    .op (s1_op_reg),
    .a  (s1_a_reg),
    .b  (s1_b_reg),
    .y  (y_next)
  );

  // out_ready reaches in_ready combinationally; there is no skid buffer.
  assign in_ready = !s1_valid_reg || !s2_valid_reg || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid_reg && out_ready;
  assign s2_load  = s1_valid_reg && (!s2_valid_reg || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (in_xfer) begin
      s1_valid_reg <= 1'b1;
      s1_op_reg    <= in_op;
      s1_a_reg     <= in_a;
      s1_b_reg     <= in_b;
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_op_reg    <= '0;
      s2_y_reg     <= '0;
      s2_zero_reg  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= 1'b1;
      s2_op_reg    <= s1_op_reg;
      s2_y_reg     <= y_next;
      s2_zero_reg  <= (y_next == '0);
    end else if (out_xfer) begin
      s2_valid_reg <= 1'b0;
    end
  end

`ifdef LZY_GATE_PARITY_EN
  logic s2_par_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_par_reg <= 1'b0;
    end else if (s2_load) begin
      s2_par_reg <= ^y_next;
    end
  end

  assign out_par = s2_par_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_reg <= '0;
    end else if (out_xfer) begin
      done_cnt_reg <= done_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_y     = s2_y_reg;
  assign out_op    = s2_op_reg;
  assign out_zero  = s2_zero_reg;
  assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_lzy_gate_pipe.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// checked against a truth-table/queue reference model.
module tb_lzy_gate_pipe;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     in_op = '0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_y;
  logic [2:0]     out_op;
  logic           out_zero;
  logic [CNT_W-1:0] done_cnt;
`ifdef LZY_GATE_PARITY_EN
  logic           out_par;
`endif

  lzy_gate_pipe #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_op    (out_op),
    .out_zero  (out_zero),
`ifdef LZY_GATE_PARITY_EN
    .out_par   (out_par),
`endif
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [3:0] tt [8];
    logic [W-1:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b0111; tt[2] = 4'b1110; tt[3] = 4'b0001;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1010;
    for (int i = 0; i < W; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] y;
    int           acc_edge;
  } exp_t;

  exp_t exp_q[$];
  exp_t out_log[$];
  int   edge_cnt = 0;
  int   model_cnt = 0;

  always @(posedge clk) edge_cnt++;

  // Monitor samples on the falling edge and predicts the coming rising edge.
  always @(negedge clk) begin
    logic exp_ready, exp_valid;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      exp_ready = (exp_q.size() < 2) || out_ready;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].acc_edge < edge_cnt);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      chk("done_cnt", 32'(done_cnt), 32'(model_cnt));
      if (exp_valid && out_valid) begin
        chk("out_y", 32'(out_y), 32'(exp_q[0].y));
        chk("out_op", 32'(out_op), 32'(exp_q[0].op));
        chk("out_zero", {31'd0, out_zero}, {31'd0, exp_q[0].y == '0});
`ifdef LZY_GATE_PARITY_EN
        chk("out_par", {31'd0, out_par}, {31'd0, ^exp_q[0].y});
`endif
      end
      if (exp_valid && out_ready) begin
        e = exp_q.pop_front();
        out_log.push_back(e);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        $display("out  op=%0d y=%h cnt=%0d", e.op, e.y, model_cnt);
      end
      if (in_valid && exp_ready) begin
        e.op = in_op;
        e.y = ref_gate(in_op, in_a, in_b);
        e.acc_edge = edge_cnt + 1;
        exp_q.push_back(e);
        $display("in   op=%0d a=%h b=%h", in_op, in_a, in_b);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    logic acc;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         zero;
  } vec_t;

  vec_t vt [10];
  vec_t bp [5];

  initial begin
    int acc_n;
    vt[0] = '{3'd0, 8'hC3, 8'hA5, 8'h81, 1'b0};
    vt[1] = '{3'd1, 8'hC3, 8'hA5, 8'h7E, 1'b0};
    vt[2] = '{3'd2, 8'hC3, 8'hA5, 8'hE7, 1'b0};
    vt[3] = '{3'd3, 8'hC3, 8'hA5, 8'h18, 1'b0};
    vt[4] = '{3'd4, 8'hC3, 8'hA5, 8'h66, 1'b0};
    vt[5] = '{3'd5, 8'hC3, 8'hA5, 8'h99, 1'b0};
    vt[6] = '{3'd6, 8'hC3, 8'hA5, 8'h3C, 1'b0};
    vt[7] = '{3'd7, 8'hC3, 8'hA5, 8'hA5, 1'b0};
    vt[8] = '{3'd4, 8'h5A, 8'h5A, 8'h00, 1'b1};
    vt[9] = '{3'd2, 8'h01, 8'h00, 8'h01, 1'b0};
    for (int i = 0; i < 5; i++) bp[i] = '{3'(i), 8'(8'h10 * i + 3), 8'(8'hF0 - i), 8'h00, 1'b0};

    // Reset held three cycles with in_valid asserted.
    in_valid = 1'b1;
    do_reset(3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_y", 32'(out_y), 32'd0);
    @(posedge clk); #1;

    // Directed vector table, back-to-back with out_ready=1.
    out_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(vt[i].op, vt[i].a, vt[i].b);
    drain();
    chk("tbl_count", 32'(out_log.size()), 32'd10);
    chk("tbl_done_cnt", 32'(done_cnt), 32'd10);
    for (int i = 0; i < 10 && i < out_log.size(); i++) begin
      chk($sformatf("tbl_y%0d", i), 32'(out_log[i].y), 32'(vt[i].y));
      chk($sformatf("tbl_zero%0d", i), {31'd0, out_log[i].y == '0}, {31'd0, vt[i].zero});
    end

    // Backpressure: only two enter while out_ready is low.
    do_reset(1);
    out_log.delete();
    out_ready = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_op = bp[acc_n].op; in_a = bp[acc_n].a; in_b = bp[acc_n].b;
      @(negedge clk);
      if (in_ready) acc_n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc_n), 32'd2);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_y", 32'(out_y), 32'(ref_gate(bp[0].op, bp[0].a, bp[0].b)));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = acc_n; i < 5; i++) send(bp[i].op, bp[i].a, bp[i].b);
    drain();
    chk("bp_count", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      chk($sformatf("bp_order%0d", i), 32'(out_log[i].y), 32'(ref_gate(bp[i].op, bp[i].a, bp[i].b)));

    // Counter wrap at 2^CNT_W.
    do_reset(1);
    for (int i = 0; i < 17; i++) send(3'(i), 8'(i * 7), 8'(i * 13));
    drain();
    chk("wrap_done_cnt", 32'(done_cnt), 32'd1);

    // Mid-stream reset with both stages full.
    do_reset(1);
    out_log.delete();
    out_ready = 1'b0;
    send(3'd2, 8'h11, 8'h22);
    send(3'd4, 8'h33, 8'h44);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_no_output", 32'(out_log.size()), 32'd0);
    chk("mrst_done_cnt", 32'(done_cnt), 32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
